// File: rtl/stream_fifo_fwft.sv
// stream_fifo_fwft: first-word-fall-through stream FIFO with occupancy count and almost-full flag
module stream_fifo_fwft #(
    parameter int DATA_WIDTH         = 64,
    parameter int DEPTH_LOG2         = 4,
    parameter int ALMOST_FULL_THRESH = 2**DEPTH_LOG2 - 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  almost_full
);
    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr, count_nxt;
    logic                  empty, full, push, pop;

    // MSB of each pointer is a wrap bit distinguishing full from empty
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) && (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb count_nxt = flush ? '0 : count + PW'(push) - PW'(pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_ptr      <= flush ? '0 : wr_ptr + PW'(push);
            rd_ptr      <= flush ? '0 : rd_ptr + PW'(pop);
            count       <= count_nxt;
            almost_full <= count_nxt >= AF_THRESH;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
    end
endmodule

// File: tb/tb_stream_fifo_fwft.sv
// tb_stream_fifo_fwft: directed and randomized checks of stream_fifo_fwft against a queue model
module tb_stream_fifo_fwft;
    localparam int DW = 16;
    localparam int DL = 2;
    localparam int DEPTH = 4;
    localparam int THRESH = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [DL:0]   count;
    logic          almost_full;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] q[$];

    stream_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .count(count), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    // Advance one clock and apply the accepted transfers to the model queue
    task automatic cycle();
        bit push, pop;
        logic [DW-1:0] d;
        push = in_valid && q.size() < DEPTH && !flush;
        pop  = out_ready && q.size() > 0 && !flush;
        d = in_data;
        @(posedge clk);
        #1;
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
    endtask

    task automatic idle();
        in_valid = 0; out_ready = 0; flush = 0;
    endtask

    task automatic test_reset();
        idle();
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b want 0", almost_full); end
        @(posedge clk); #3;
        resetn = 1;
        @(posedge clk); #1;
        q.delete();
        checks++; if (in_ready !== 1'b1 || count !== 0) begin errors++; $display("FAIL post_reset in_ready=%b count=%0d want 1,0", in_ready, count); end
    endtask

    task automatic test_single();
        idle();
        in_valid = 1; in_data = 16'h0011;
        cycle();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 16'h0011) begin errors++; $display("FAIL single_data got %h want 0011", out_data); end
        checks++; if (count !== 1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
        out_ready = 1;
        cycle();
        out_ready = 0;
        checks++; if (out_valid !== 1'b0 || count !== 0) begin errors++; $display("FAIL single_drain valid=%b count=%0d want 0,0", out_valid, count); end
    endtask

    task automatic test_fill_drain();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; in_data = DW'(16'hA0 + i);
            cycle();
            checks++; if (count !== DL'(0) + (DL+1)'(q.size())) begin errors++; $display("FAIL fill_count got %0d want %0d", count, q.size()); end
            checks++; if (almost_full !== (q.size() >= THRESH)) begin errors++; $display("FAIL fill_almost_full got %b at size %0d", almost_full, q.size()); end
        end
        checks++; if (count !== 4 || in_ready !== 1'b0 || almost_full !== 1'b1) begin errors++; $display("FAIL full_state count=%0d in_ready=%b af=%b want 4,0,1", count, in_ready, almost_full); end
        in_data = 16'h00A4;
        cycle();
        in_valid = 0;
        checks++; if (count !== 4) begin errors++; $display("FAIL overflow_count got %0d want 4", count); end
        out_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== DW'(16'hA0 + i)) begin errors++; $display("FAIL drain_data got %b/%h want 1/%h", out_valid, out_data, 16'hA0 + i); end
            cycle();
        end
        out_ready = 0;
        checks++; if (count !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_end count=%0d valid=%b want 0,0", count, out_valid); end
    endtask

    task automatic test_full_pop();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; in_data = DW'(16'hB0 + i);
            cycle();
        end
        in_data = 16'h00B4; out_ready = 1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_in_ready_before got %b want 0", in_ready); end
        cycle();
        out_ready = 0;
        checks++; if (count !== 3 || in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_after count=%0d in_ready=%b want 3,1", count, in_ready); end
        checks++; if (out_data !== 16'h00B1) begin errors++; $display("FAIL fullpop_head got %h want 00b1", out_data); end
        cycle();
        in_valid = 0;
        checks++; if (count !== 4 || in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_refill count=%0d in_ready=%b want 4,0", count, in_ready); end
        out_ready = 1;
        for (int i = 1; i <= DEPTH; i++) begin
            checks++; if (out_data !== DW'(16'hB0 + i)) begin errors++; $display("FAIL fullpop_order got %h want %h", out_data, 16'hB0 + i); end
            cycle();
        end
        out_ready = 0;
    endtask

    task automatic test_back_to_back();
        idle();
        in_valid = 1; in_data = 0;
        cycle();
        out_ready = 1;
        for (int i = 1; i <= 3 * DEPTH; i++) begin
            in_data = DW'(i);
            checks++; if (out_valid !== 1'b1 || out_data !== DW'(i - 1)) begin errors++; $display("FAIL stream_data got %b/%0d want 1/%0d", out_valid, out_data, i - 1); end
            checks++; if (count !== 1) begin errors++; $display("FAIL stream_count got %0d want 1", count); end
            cycle();
        end
        in_valid = 0;
        cycle();
        out_ready = 0;
        checks++; if (count !== 0) begin errors++; $display("FAIL stream_end got %0d want 0", count); end
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = DW'(16'hC0 + i);
            cycle();
        end
        checks++; if (count !== 3) begin errors++; $display("FAIL flush_pre got %0d want 3", count); end
        out_ready = 1; flush = 1; in_data = 16'h00CF;
        cycle();
        idle();
        checks++; if (count !== 0 || out_valid !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL flush_post count=%0d valid=%b af=%b want 0,0,0", count, out_valid, almost_full); end
        in_valid = 1; in_data = 16'h00D5;
        cycle();
        in_valid = 0;
        checks++; if (out_data !== 16'h00D5 || count !== 1) begin errors++; $display("FAIL flush_next data=%h count=%0d want 00d5,1", out_data, count); end
        out_ready = 1;
        cycle();
        out_ready = 0;
    endtask

    task automatic test_async_reset();
        idle();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_data = DW'(16'hE0 + i);
            cycle();
        end
        in_valid = 0;
        checks++; if (count !== 2 || almost_full !== 1'b1) begin errors++; $display("FAIL areset_pre count=%0d af=%b want 2,1", count, almost_full); end
        #2 resetn = 0;
        #1;
        checks++; if (count !== 0 || out_valid !== 1'b0 || almost_full !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL areset_now count=%0d valid=%b af=%b in_ready=%b want 0,0,0,1", count, out_valid, almost_full, in_ready); end
        q.delete();
        #4 resetn = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        idle();
        for (int n = 0; n < 400; n++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 24) == 0;
            in_data   = DW'($urandom);
            checks++; if (count !== (DL+1)'(q.size())) begin errors++; $display("FAIL rand_count cycle %0d got %0d want %0d", n, count, q.size()); end
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_valid cycle %0d got %b want %b", n, out_valid, q.size() > 0); end
            checks++; if (in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rand_ready cycle %0d got %b want %b", n, in_ready, q.size() < DEPTH); end
            checks++; if (almost_full !== (q.size() >= THRESH)) begin errors++; $display("FAIL rand_af cycle %0d got %b want %b", n, almost_full, q.size() >= THRESH); end
            if (q.size() > 0) begin
                checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rand_data cycle %0d got %h want %h", n, out_data, q[0]); end
            end
            cycle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_full_pop();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_fifo_fwft.md
STREAM_FIFO_FWFT -- requirements
Module: stream_fifo_fwft

Interface
REQ-001 Parameter DATA_WIDTH, default 64, is the payload width in bits.
REQ-002 Parameter DEPTH_LOG2, default 4, is log2 of the storage depth; DEPTH = 2**DEPTH_LOG2; legal range 1..10.
REQ-003 Parameter ALMOST_FULL_THRESH, default 2**DEPTH_LOG2 - 2, is the occupancy at which almost_full asserts; legal range 1..DEPTH.
REQ-004 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 Port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_data, input, DATA_WIDTH bits: write payload.
REQ-007 Port in_valid, input, 1 bit: write payload valid.
REQ-008 Port in_ready, output, 1 bit: FIFO accepts in_data this cycle.
REQ-009 Port out_data, output, DATA_WIDTH bits: head-of-FIFO payload.
REQ-010 Port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-011 Port out_ready, input, 1 bit: downstream consumes the head this cycle.
REQ-012 Port flush, input, 1 bit: synchronous discard of all stored entries.
REQ-013 Port count, output, DEPTH_LOG2+1 bits: current occupancy, 0..DEPTH.
REQ-014 Port almost_full, output, 1 bit: count >= ALMOST_FULL_THRESH.

Function
REQ-015 Storage: DEPTH entries of DATA_WIDTH bits; read and write pointers DEPTH_LOG2+1 bits wide, MSB used as wrap bit.
REQ-016 empty = (wr_ptr == rd_ptr); full = (low bits equal) and (wrap bits differ).
REQ-017 in_ready = ~full; combinational from registered state only, never from in_valid or out_ready.
REQ-018 out_valid = ~empty; out_data = storage[rd_ptr low bits] (first-word-fall-through); neither depends combinationally on in_valid or out_ready.
REQ-019 push = in_valid & in_ready & ~flush; on push, in_data is written at wr_ptr and wr_ptr increments at the clock edge.
REQ-020 pop = out_valid & out_ready & ~flush; on pop, rd_ptr increments at the clock edge.
REQ-021 Write-to-read latency: a word pushed into an empty FIFO at edge N appears with out_valid=1 in the cycle after edge N (1 cycle).
REQ-022 Simultaneous push and pop with 0 < count < DEPTH: both occur; count unchanged.
REQ-023 Full (count = DEPTH): in_ready=0; a pop in that cycle frees a slot; in_ready rises the following cycle (no same-cycle pass-through).
REQ-024 Empty: out_valid=0; out_ready is ignored; no underflow possible.
REQ-025 Pointer wrap: pointers increment modulo 2*DEPTH; data order is preserved across wrap.
REQ-026 flush=1 at an edge: rd_ptr <= wr_ptr... no, both pointers <= 0, count <= 0; flush overrides push and pop in the same cycle; stored data contents are don't-care.
REQ-027 count is a register updated at the same edge as the pointers: +1 on push only, -1 on pop only, unchanged on both or neither, 0 on flush.
REQ-028 almost_full is registered, updated from the next-state count, so it is consistent with count every cycle.
REQ-029 Input-side behaviour when in_valid=0 or out_ready=0 on the output side is purely AXI-stream: data and valid held until accepted; the FIFO never drops a pushed word except on flush or reset.

Reset
REQ-030 resetn=0 asynchronously clears wr_ptr, rd_ptr, count and almost_full to 0, without waiting for clk.
REQ-031 During and immediately after reset: out_valid=0, in_ready=1 (the first cycle after deassertion accepts data), count=0, almost_full=0; out_data is don't-care.
REQ-032 Reset asserted mid-transfer discards all entries; no push or pop is recorded at the edge coincident with reset.
REQ-033 Storage array is not reset.

Verification
REQ-034 Reset then push 0x11 with out_ready=0 -> next cycle out_valid=1, out_data=0x11, count=1.
REQ-035 DEPTH_LOG2=2: push 4 words (0xA0..0xA3) with out_ready=0 -> count=4, in_ready=0, almost_full=1; a fifth in_valid is not accepted; then drain -> outputs 0xA0,0xA1,0xA2,0xA3 in order, count returns to 0.
REQ-036 Steady stream with in_valid=out_ready=1 for 3*DEPTH cycles (pointer wrap) -> count constant, sequence 0..3*DEPTH-1 emerges in order with no gaps.
REQ-037 Full FIFO, assert out_ready for one cycle with in_valid=1 -> one pop occurs, in_ready=1 on the next cycle, count = DEPTH-1 then back to DEPTH after the next push.
REQ-038 count=3, assert flush with in_valid=out_ready=1 -> next cycle count=0, out_valid=0, no word pushed or popped.
REQ-039 Assert resetn=0 between clock edges with count=2 -> count, out_valid, almost_full go to 0 immediately without a clock edge; in_ready=1.
